// File: rtl/frq_sweep_ctrl.sv
// rtl/frq_sweep_ctrl.sv - frequency-select sweep sequencer for the ROM-controlled divider
module frq_sweep_ctrl #(
  parameter int SEL_W   = 5,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [SEL_W-1:0]   lo_sel,
  input  logic [SEL_W-1:0]   hi_sel,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               pingpong,
  input  logic               continuous,
  input  logic               div_clk,
  output logic [SEL_W-1:0]   f_select,
  output logic               busy,
  output logic               step_strobe,
  output logic               done,
  output logic               cfg_err
);

  typedef enum logic [1:0] {IDLE, DWELL, STEP, DONE} state_t;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   lo_q, hi_q, f_nxt;
  logic [DWELL_W-1:0] dwell_q, dwell_last, cnt, cnt_nxt;
  logic               pp_q, cont_q, dir, dir_nxt;
  logic               latch_cfg, cfg_err_nxt;
  logic               sync1, sync2, sync3, rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= div_clk;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;

  // A programmed dwell of zero behaves as one divided period.
  assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);

  always_comb begin
    state_nxt   = state;
    f_nxt       = f_select;
    dir_nxt     = dir;
    cnt_nxt     = cnt;
    latch_cfg   = 1'b0;
    cfg_err_nxt = 1'b0;
    if (state != IDLE && abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            if (lo_sel > hi_sel) begin
              cfg_err_nxt = 1'b1;
            end else begin
              latch_cfg = 1'b1;
              f_nxt     = lo_sel;
              dir_nxt   = 1'b0;
              cnt_nxt   = '0;
              state_nxt = DWELL;
            end
          end
        end
        DWELL: begin
          if (rise) begin
            if (cnt == dwell_last) begin
              cnt_nxt = '0;
              if (!dir && f_select < hi_q) begin
                f_nxt     = f_select + SEL_W'(1);
                state_nxt = STEP;
              end else if (!dir && pp_q && lo_q != hi_q) begin
                dir_nxt   = 1'b1;
                f_nxt     = f_select - SEL_W'(1);
                state_nxt = STEP;
              end else if (dir && f_select > lo_q) begin
                f_nxt     = f_select - SEL_W'(1);
                state_nxt = STEP;
              end else if (cont_q) begin
                f_nxt     = lo_q;
                dir_nxt   = 1'b0;
                state_nxt = STEP;
              end else begin
                state_nxt = DONE;
              end
            end else begin
              cnt_nxt = cnt + DWELL_W'(1);
            end
          end
        end
        STEP: begin
          cnt_nxt   = '0;
          state_nxt = DWELL;
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      f_select <= '0;
      dir      <= 1'b0;
      cnt      <= '0;
      cfg_err  <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      dwell_q  <= '0;
      pp_q     <= 1'b0;
      cont_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      f_select <= f_nxt;
      dir      <= dir_nxt;
      cnt      <= cnt_nxt;
      cfg_err  <= cfg_err_nxt;
      if (latch_cfg) begin
        lo_q    <= lo_sel;
        hi_q    <= hi_sel;
        dwell_q <= dwell;
        pp_q    <= pingpong;
        cont_q  <= continuous;
      end
    end
  end

  assign busy        = (state != IDLE);
  assign step_strobe = (state == STEP);
  assign done        = (state == DONE);

endmodule

// File: tb/tb_frq_sweep_ctrl.sv
// tb/tb_frq_sweep_ctrl.sv - randomized self-checking bench for frq_sweep_ctrl
module tb_frq_sweep_ctrl;
  localparam int SEL_W   = 5;
  localparam int DWELL_W = 8;

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic               start = 1'b0, abort = 1'b0;
  logic [SEL_W-1:0]   lo_sel = '0, hi_sel = '0;
  logic [DWELL_W-1:0] dwell = '0;
  logic               pingpong = 1'b0, continuous = 1'b0, div_clk = 1'b0;
  logic [SEL_W-1:0]   f_select;
  logic               busy, step_strobe, done, cfg_err;

  frq_sweep_ctrl #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .lo_sel(lo_sel), .hi_sel(hi_sel), .dwell(dwell), .pingpong(pingpong),
    .continuous(continuous), .div_clk(div_clk), .f_select(f_select),
    .busy(busy), .step_strobe(step_strobe), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: the sweep is a precomputed list of select values walked
  // one entry per completed dwell; divider rises take effect two edges after sampling.
  int m_seq[$];
  int m_idx, m_rcnt, m_dwell, m_f;
  bit m_cont, m_active, m_step, m_done, m_cfg;
  bit div_prev, hist0, hist1;
  int half = 2;
  int phase = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit rise_now, rise_eff;
    rise_now = div_clk && !div_prev;
    div_prev = div_clk;
    rise_eff = hist1;
    hist1    = hist0;
    hist0    = rise_now;
    m_cfg    = 1'b0;
    if (m_done) begin
      m_active = 1'b0;
      m_done   = 1'b0;
    end else if (m_active && abort) begin
      m_active = 1'b0;
      m_step   = 1'b0;
    end else if (m_step) begin
      m_step = 1'b0;
      m_rcnt = 0;
    end else if (m_active) begin
      if (rise_eff) begin
        m_rcnt++;
        if (m_rcnt >= m_dwell) begin
          m_rcnt = 0;
          if (m_idx + 1 < m_seq.size()) begin
            m_idx++;
            m_f    = m_seq[m_idx];
            m_step = 1'b1;
          end else if (m_cont) begin
            m_idx  = 0;
            m_f    = m_seq[0];
            m_step = 1'b1;
          end else begin
            m_done = 1'b1;
          end
        end
      end
    end else if (start && !abort) begin
      if (lo_sel > hi_sel) begin
        m_cfg = 1'b1;
      end else begin
        m_seq.delete();
        for (int v = int'(lo_sel); v <= int'(hi_sel); v++) m_seq.push_back(v);
        if (pingpong && lo_sel != hi_sel)
          for (int v = int'(hi_sel) - 1; v >= int'(lo_sel); v--) m_seq.push_back(v);
        m_active = 1'b1;
        m_f      = int'(lo_sel);
        m_idx    = 0;
        m_rcnt   = 0;
        m_dwell  = (dwell == '0) ? 1 : int'(dwell);
        m_cont   = continuous;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("f_select", f_select, m_f);
    check_eq("busy", busy, m_active);
    check_eq("step_strobe", step_strobe, m_step);
    check_eq("done", done, m_done);
    check_eq("cfg_err", cfg_err, m_cfg);
    phase++;
    if (phase >= half) begin
      phase   = 0;
      div_clk = ~div_clk;
    end
  endtask

  task automatic do_reset();
    start = 1'b0;
    abort = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_f_select", f_select, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_step_strobe", step_strobe, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_cfg_err", cfg_err, 0);
    m_active = 0; m_step = 0; m_done = 0; m_cfg = 0; m_f = 0;
    div_prev = 0; hist0 = 0; hist1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_sweep(input int lo, input int hi, input int dw, input bit pp,
                           input bit cont, input int ncyc, input bit noise);
    lo_sel     = SEL_W'(lo);
    hi_sel     = SEL_W'(hi);
    dwell      = DWELL_W'(dw);
    pingpong   = pp;
    continuous = cont;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < ncyc && m_active; i++) begin
      if (noise) begin
        lo_sel     = SEL_W'($urandom);
        hi_sel     = SEL_W'($urandom);
        dwell      = DWELL_W'($urandom);
        pingpong   = 1'($urandom);
        continuous = 1'($urandom);
        start      = ($urandom_range(0, 7) == 0);
        abort      = ($urandom_range(0, 299) == 0);
      end
      tick();
      start = 1'b0;
      abort = 1'b0;
    end
    if (!cont) check_eq("sweep_end_busy", busy, 0);
    if (busy || m_active) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_eq("abort_busy", busy, 0);
    end
  endtask

  initial begin
    do_reset();
    repeat (3) tick();

    half = 4;
    run_sweep(3, 5, 2, 0, 0, 2000, 0);
    check_eq("upcnt_hold_f", f_select, 5);

    half = 2;
    run_sweep(2, 4, 1, 1, 0, 2000, 0);

    half = 3;
    run_sweep(7, 7, 0, 1, 1, 80, 0);
    check_eq("cont_abort_f", f_select, 7);

    lo_sel = 9; hi_sel = 4; start = 1'b1;
    tick();
    start = 1'b0;
    tick();

    half = 2;
    run_sweep(1, 4, 2, 1, 0, 3000, 1);

    lo_sel = 1; hi_sel = 3; dwell = 1; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (4) tick();

    lo_sel = 2; hi_sel = 6; dwell = 3; pingpong = 0; continuous = 0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    do_reset();
    run_sweep(1, 2, 1, 0, 0, 2000, 0);

    for (int r = 0; r < 30; r++) begin
      int lo, hi;
      lo   = $urandom_range(0, 26);
      hi   = lo + $urandom_range(0, 4);
      if ($urandom_range(0, 7) == 0 && lo > 0) hi = lo - 1;
      half = $urandom_range(1, 4);
      run_sweep(lo, hi, $urandom_range(0, 3), 1'($urandom), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 1) == 1) ? 150 : 3000, 1'($urandom));
      repeat ($urandom_range(1, 4)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
